// File: rtl/systolic_matrix_loader.sv
// systolic_matrix_loader: assembles a row-major element stream into an
// N x N matrix, kicks the systolic array and holds the matrix until done.
module systolic_matrix_loader #(
  parameter int N   = 10,
  parameter int DW  = 16,
  parameter int FCW = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DW-1:0]                   s_data,
  input  logic                            s_last,
  output logic [N-1:0][N-1:0][DW-1:0]     A,
  output logic                            sa_start,
  input  logic                            sa_done,
  output logic                            busy,
  output logic                            err_len,
  output logic [FCW-1:0]                  frames
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [IW-1:0]                 row_q, row_d;
  logic [IW-1:0]                 col_q, col_d;
  logic [N-1:0][N-1:0][DW-1:0]   a_q, a_d;
  logic                          start_q, start_d;
  logic                          busy_q, busy_d;
  logic                          err_q, err_d;
  logic [FCW-1:0]                frames_q, frames_d;
  logic                          beat;
  logic                          row_end;
  logic                          col_end;

  assign s_ready  = (state_q == LOAD);
  assign beat     = s_valid && s_ready;
  assign row_end  = (row_q == LAST_IDX);
  assign col_end  = (col_q == LAST_IDX);

  assign A        = a_q;
  assign sa_start = start_q;
  assign busy     = busy_q;
  assign err_len  = err_q;
  assign frames   = frames_q;

  // Next-state: element placement, framing checks, fire/wait sequencing
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    a_d      = a_q;
    err_d    = err_q;
    frames_d = frames_q;
    unique case (state_q)
      LOAD: begin
        if (beat) begin
          a_d[row_q][col_q] = s_data;
          if (row_end && col_end) begin
            row_d   = '0;
            col_d   = '0;
            state_d = FIRE;
            if (!s_last) err_d = 1'b1;
          end else if (s_last) begin
            row_d = '0;
            col_d = '0;
            err_d = 1'b1;
          end else if (col_end) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      FIRE: begin
        frames_d = frames_q + 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (sa_done) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
    start_d = (state_d == FIRE);
    busy_d  = (state_d != LOAD);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      row_q    <= '0;
      col_q    <= '0;
      a_q      <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      a_q      <= a_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      frames_q <= frames_d;
    end
  end

endmodule

// File: tb/tb_systolic_matrix_loader.sv
// tb_systolic_matrix_loader: random/directed frames, frame-level model,
// scoreboard queue popped by a monitor on each sa_start.
module tb_systolic_matrix_loader;

  localparam int N   = 10;
  localparam int DW  = 16;
  localparam int FCW = 8;
  localparam int NE  = N * N;

  typedef logic [NE*DW-1:0] mat_t;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        s_valid = 1'b0;
  logic                        s_ready;
  logic [DW-1:0]               s_data = '0;
  logic                        s_last = 1'b0;
  logic [N-1:0][N-1:0][DW-1:0] A;
  logic                        sa_start;
  logic                        sa_done = 1'b0;
  logic                        busy;
  logic                        err_len;
  logic [FCW-1:0]              frames;

  systolic_matrix_loader #(.N(N), .DW(DW), .FCW(FCW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .A(A), .sa_start(sa_start), .sa_done(sa_done),
    .busy(busy), .err_len(err_len), .frames(frames)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  mat_t           mvec = '0;
  int             mcnt = 0;
  bit             merr = 1'b0;
  logic [FCW-1:0] mfr = '0;

  mat_t           q_m[$];
  bit             q_err[$];
  logic [FCW-1:0] q_fr[$];

  mat_t           cur_exp = '0;
  bit             hold_done = 1'b0;
  logic [DW-1:0]  fd [NE];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_mat(input string name, input mat_t act,
                         input mat_t exp);
    int bad;
    bad = -1;
    checks++;
    for (int i = NE - 1; i >= 0; i--)
      if (act[i*DW +: DW] !== exp[i*DW +: DW]) bad = i;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s elem[%0d][%0d] actual=%0h expected=%0h",
               name, bad / N, bad % N,
               act[bad*DW +: DW], exp[bad*DW +: DW]);
    end
  endtask

  // frame-level model of an accepted beat
  task automatic model_accept(input logic [DW-1:0] d, input logic l);
    mvec[mcnt*DW +: DW] = d;
    if (mcnt == NE - 1) begin
      if (!l) merr = 1'b1;
      q_m.push_back(mvec);
      q_err.push_back(merr);
      q_fr.push_back(mfr);
      mfr  = mfr + 1'b1;
      mcnt = 0;
    end else if (l) begin
      merr = 1'b1;
      mcnt = 0;
    end else begin
      mcnt++;
    end
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic l,
                      input bit gap);
    int n;
    if (gap) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    n = 0;
    while (!s_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout actual=not_ready expected=ready");
    end else begin
      @(posedge clk);
      model_accept(d, l);
    end
  endtask

  task automatic send(input int len, input int last_pos,
                      input int gapmode);
    bit g;
    for (int i = 0; i < len; i++) begin
      g = 1'b0;
      if (gapmode == 1) g = (i % 3 == 2);
      if (gapmode == 2) g = ($urandom_range(0, 3) == 0);
      beat(fd[i], (i == last_pos), g);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(s_ready && !busy && q_m.size() == 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_fd();
    for (int i = 0; i < NE; i++) fd[i] = DW'($urandom);
  endtask

  // monitor: pop expected frame on every start pulse
  initial begin
    logic [FCW-1:0] efr;
    forever begin
      @(negedge clk);
      if (sa_start) begin
        if (q_m.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL start_unexpected actual=1 expected=0");
        end else begin
          cur_exp = q_m.pop_front();
          efr     = q_fr.pop_front();
          chk_mat("start_matrix", mat_t'(A), cur_exp);
          chk("start_err_len", 32'(err_len), 32'(q_err.pop_front()));
          chk("start_frames", 32'(frames), 32'(efr));
          @(negedge clk);
          chk("start_one_cycle", 32'(sa_start), 32'd0);
          chk("frames_incr", 32'(frames), 32'(FCW'(efr + 1'b1)));
        end
      end
    end
  end

  // array model: random done latency, checks the hold window
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (sa_start) begin
        if (hold_done) begin
          while (hold_done) @(negedge clk);
        end else begin
          d = $urandom_range(0, 4);
          if (d == 0) sa_done = 1'b1;
          @(negedge clk);
          for (int i = 0; i < d; i++) begin
            chk("wait_ready", 32'(s_ready), 32'd0);
            chk("wait_busy", 32'(busy), 32'd1);
            @(negedge clk);
          end
          sa_done = 1'b1;
          chk("wait_ready_done", 32'(s_ready), 32'd0);
          chk_mat("hold_matrix", mat_t'(A), cur_exp);
          @(negedge clk);
          sa_done = 1'b0;
          chk("ready_after_done", 32'(s_ready), 32'd1);
          chk("busy_after_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(sa_start), 32'd0);
    chk("rst_err", 32'(err_len), 32'd0);
    chk("rst_frames", 32'(frames), 32'd0);
    chk_mat("rst_matrix", mat_t'(A), '0);
    rst = 1'b0;

    // basic 0..99 frame
    for (int i = 0; i < NE; i++) fd[i] = DW'(i);
    send(NE, NE - 1, 0);
    idle();
    wait_idle();
    chk("basic_a37", 32'(A[3][7]), 32'd37);
    chk("basic_a99", 32'(A[9][9]), 32'd99);
    chk("basic_frames", 32'(frames), 32'd1);
    chk("basic_err", 32'(err_len), 32'd0);

    // gapped frame, then 0x7FFF held through WAIT
    send(NE, NE - 1, 1);
    rand_fd();
    fd[0] = 16'h7FFF;
    send(NE, NE - 1, 2);
    idle();
    wait_idle();

    // signed extremes
    rand_fd();
    fd[0]  = 16'h8000;
    fd[55] = 16'hFFFF;
    fd[99] = 16'h7FFF;
    send(NE, NE - 1, 0);
    idle();
    wait_idle();
    chk("signed_a00", 32'(A[0][0]), 32'h8000);
    chk("signed_a55", 32'(A[5][5]), 32'hFFFF);
    chk("signed_a99", 32'(A[9][9]), 32'h7FFF);
    chk("signed_err", 32'(err_len), 32'd0);

    // early last on beat 40, then clean frame
    rand_fd();
    send(41, 40, 0);
    idle();
    repeat (3) @(negedge clk);
    chk("early_err", 32'(err_len), 32'd1);
    chk("early_no_busy", 32'(busy), 32'd0);
    chk("early_ready", 32'(s_ready), 32'd1);
    rand_fd();
    send(NE, NE - 1, 0);
    idle();
    wait_idle();
    chk("early_frames", 32'(frames), 32'd5);
    chk("early_err_sticky", 32'(err_len), 32'd1);

    // missing last
    rand_fd();
    send(NE, -1, 2);
    idle();
    wait_idle();
    chk("nolast_frames", 32'(frames), 32'd6);

    // random frames with occasional early lasts
    for (int f = 0; f < 6; f++) begin
      rand_fd();
      if ($urandom_range(0, 2) == 0)
        send($urandom_range(1, NE - 1), -2, 2);
      send(NE, ($urandom_range(0, 3) == 0) ? -1 : NE - 1, 2);
    end
    idle();
    wait_idle();

    // reset while waiting for done
    hold_done = 1'b1;
    rand_fd();
    send(NE, NE - 1, 0);
    idle();
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_mat("rst2_matrix", mat_t'(A), '0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_ready", 32'(s_ready), 32'd1);
    chk("rst2_frames", 32'(frames), 32'd0);
    chk("rst2_err", 32'(err_len), 32'd0);
    mvec = '0;
    mcnt = 0;
    merr = 1'b0;
    mfr  = '0;
    q_m.delete();
    q_err.delete();
    q_fr.delete();
    hold_done = 1'b0;
    @(negedge clk);
    chk("rst2_no_start", 32'(sa_start), 32'd0);

    // 256 clean frames wrap the counter
    for (int f = 0; f < 256; f++) begin
      rand_fd();
      send(NE, NE - 1, 0);
    end
    idle();
    wait_idle();
    chk("wrap_frames", 32'(frames), 32'd0);
    chk("wrap_err", 32'(err_len), 32'd0);
    chk("queue_drained", 32'(q_m.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
